// File: rtl/vmul_unit_tm.sv
// Time-multiplexed vector multiplier: NUMLANES element pairs through NUMMULLANES multipliers, one lane group per cycle.
// Optional feature: define VMUL_MASKSKIP_EN to skip groups whose lane-enable bits are all zero.
module vmul_unit_tm #(
    parameter int LOG2WIDTH    = 5,
    parameter int LOG2NUMLANES = 4,
    parameter int NUMMULLANES  = 4,
    parameter int REGIDWIDTH   = 4,
    localparam int WIDTH       = 2 ** LOG2WIDTH,
    localparam int NUMLANES    = 2 ** LOG2NUMLANES
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      en,
    input  logic                      squash,
    input  logic                      activate,
    input  logic [4:0]                op,
    input  logic [NUMLANES*WIDTH-1:0] opA,
    input  logic [NUMLANES*WIDTH-1:0] opB,
    input  logic [LOG2WIDTH-1:0]      vshamt,
    input  logic [NUMLANES-1:0]       vmask,
    input  logic [REGIDWIDTH-1:0]     in_dst,
    input  logic                      in_dst_we,
    output logic                      stall,
    output logic [NUMLANES*WIDTH-1:0] result,
    output logic                      out_valid,
    output logic [REGIDWIDTH-1:0]     out_dst,
    output logic                      out_dst_we,
    output logic [NUMLANES-1:0]       out_dst_mask
);
    localparam int G  = NUMLANES / NUMMULLANES;
    localparam int M  = NUMMULLANES;
    localparam int GW = M * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [NUMLANES*WIDTH-1:0] r_opa, r_opb, r_work, r_result;
    logic [NUMLANES-1:0]       r_mask, r_out_mask;
    logic [2:0]                r_op;
    logic [LOG2WIDTH-1:0]      r_vshamt;
    logic [REGIDWIDTH-1:0]     r_dst, r_out_dst;
    logic                      r_dst_we, r_out_dst_we;
    logic [G-1:0]              r_pend;

    logic [G-1:0]              w_gact, w_cur_oh;
    logic                      w_found, w_last, w_accept, w_proc;
    logic [GW-1:0]             w_sel_a, w_sel_b, w_grp_res;
    logic [M-1:0]              w_sel_m;
    logic [NUMLANES*WIDTH-1:0] w_merged;
    logic                      w_unused_op;

    assign w_unused_op = ^op[4:3];
    assign w_accept    = en & activate & ~squash & (r_state != S_BUSY);
    assign w_proc      = en & ~squash & (r_state == S_BUSY);
    assign w_last      = ((r_pend & ~w_cur_oh) == '0);

    generate
        for (genvar gi = 0; gi < G; gi++) begin : g_grp
`ifdef VMUL_MASKSKIP_EN
            assign w_gact[gi] = |vmask[gi*M +: M];
`else
            assign w_gact[gi] = 1'b1;
`endif
            assign w_merged[gi*GW +: GW] = w_cur_oh[gi] ? w_grp_res : r_work[gi*GW +: GW];
        end
    endgenerate

    // Lowest pending group is serviced first; one-hot select keeps the operand mux index-free.
    always_comb begin
        w_cur_oh = '0;
        w_found  = 1'b0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_m  = '0;
        for (int g = 0; g < G; g++) begin
            if (r_pend[g] && !w_found) begin
                w_cur_oh[g] = 1'b1;
                w_found     = 1'b1;
            end
        end
        for (int g = 0; g < G; g++) begin
            if (w_cur_oh[g]) begin
                w_sel_a = w_sel_a | r_opa[g*GW +: GW];
                w_sel_b = w_sel_b | r_opb[g*GW +: GW];
                w_sel_m = w_sel_m | r_mask[g*M +: M];
            end
        end
    end

    localparam logic signed [2*WIDTH:0] FX_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH:0] FX_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic        [2*WIDTH:0] FU_MAX = {{(WIDTH+1){1'b0}}, {WIDTH{1'b1}}};

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_mul
            logic        [WIDTH-1:0]   w_a, w_b, w_lane;
            logic signed [2*WIDTH-1:0] w_sp;
            logic        [2*WIDTH-1:0] w_up;
            logic        [2*WIDTH:0]   w_rnd, w_fu;
            logic signed [2*WIDTH:0]   w_fs;

            assign w_a   = w_sel_a[gi*WIDTH +: WIDTH];
            assign w_b   = w_sel_b[gi*WIDTH +: WIDTH];
            assign w_sp  = $signed({{WIDTH{w_a[WIDTH-1]}}, w_a}) * $signed({{WIDTH{w_b[WIDTH-1]}}, w_b});
            assign w_up  = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
            assign w_rnd = (r_vshamt != '0) ? ((2*WIDTH+1)'(1) << (r_vshamt - LOG2WIDTH'(1))) : '0;
            // One guard bit above the 2W product so the rounding add cannot wrap.
            assign w_fs  = ($signed({w_sp[2*WIDTH-1], w_sp}) + $signed(w_rnd)) >>> r_vshamt;
            assign w_fu  = ({1'b0, w_up} + w_rnd) >> r_vshamt;

            always_comb begin
                w_lane = w_sp[WIDTH-1:0];
                case (r_op)
                    3'b001: w_lane = w_sp[2*WIDTH-1:WIDTH];
                    3'b010: w_lane = w_up[2*WIDTH-1:WIDTH];
                    3'b100: begin
                        if (w_fs > FX_MAX)      w_lane = FX_MAX[WIDTH-1:0];
                        else if (w_fs < FX_MIN) w_lane = FX_MIN[WIDTH-1:0];
                        else                    w_lane = w_fs[WIDTH-1:0];
                    end
                    3'b101: w_lane = (w_fu > FU_MAX) ? {WIDTH{1'b1}} : w_fu[WIDTH-1:0];
                    default: w_lane = w_sp[WIDTH-1:0];
                endcase
            end

            assign w_grp_res[gi*WIDTH +: WIDTH] = w_sel_m[gi] ? w_lane : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (en) begin
            case (r_state)
                S_BUSY: begin
                    if (squash)      w_state_next = S_IDLE;
                    else if (w_last) w_state_next = S_DONE;
                end
                default: begin
                    if (squash)        w_state_next = S_IDLE;
                    else if (activate) w_state_next = (w_gact == '0) ? S_DONE : S_BUSY;
                    else               w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_opa <= '0; r_opb <= '0; r_mask <= '0; r_op <= '0; r_vshamt <= '0;
            r_dst <= '0; r_dst_we <= 1'b0; r_pend <= '0; r_work <= '0;
            r_result <= '0; r_out_dst <= '0; r_out_dst_we <= 1'b0; r_out_mask <= '0;
        end else if (w_accept) begin
            r_opa <= opA; r_opb <= opB; r_mask <= vmask; r_op <= op[2:0]; r_vshamt <= vshamt;
            r_dst <= in_dst; r_dst_we <= in_dst_we; r_pend <= w_gact; r_work <= '0;
            if (w_gact == '0) begin
                r_result <= '0; r_out_dst <= in_dst; r_out_dst_we <= in_dst_we; r_out_mask <= vmask;
            end
        end else if (w_proc) begin
            r_work <= w_merged;
            r_pend <= r_pend & ~w_cur_oh;
            // Published outputs only change at completion, so they stay stable between strobes.
            if (w_last) begin
                r_result <= w_merged; r_out_dst <= r_dst; r_out_dst_we <= r_dst_we; r_out_mask <= r_mask;
            end
        end
    end

    assign stall        = (r_state == S_BUSY);
    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign out_dst      = r_out_dst;
    assign out_dst_we   = r_out_dst_we;
    assign out_dst_mask = r_out_mask;
endmodule

// File: tb/tb_vmul_unit_tm.sv
// Directed bench for vmul_unit_tm (WIDTH=32, 16 lanes, 4 multipliers); latencies follow VMUL_MASKSKIP_EN.
module tb_vmul_unit_tm;
`ifdef VMUL_MASKSKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk, resetn, en, squash, activate, in_dst_we;
    logic [4:0]   op, vshamt;
    logic [511:0] opA, opB;
    logic [15:0]  vmask;
    logic [3:0]   in_dst;
    logic         stall, out_valid, out_dst_we;
    logic [511:0] result;
    logic [3:0]   out_dst;
    logic [15:0]  out_dst_mask;

    int passes = 0, fails = 0, total = 0;

    vmul_unit_tm dut (
        .clk(clk), .resetn(resetn), .en(en), .squash(squash), .activate(activate),
        .op(op), .opA(opA), .opB(opB), .vshamt(vshamt), .vmask(vmask),
        .in_dst(in_dst), .in_dst_we(in_dst_we), .stall(stall), .result(result),
        .out_valid(out_valid), .out_dst(out_dst), .out_dst_we(out_dst_we),
        .out_dst_mask(out_dst_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0]  t_op [12] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
                               3'b101, 3'b101, 3'b000, 3'b011, 3'b001, 3'b100};
    logic [31:0] t_a  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'h00018000, 32'h3, 32'h7FFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] t_b  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'h00020000, 32'h1, 32'h7FFFFFFF, 32'h7FFFFFFF,
                               32'h2, 32'h1, 32'h5, 32'h7, 32'h5, 32'h1};
    logic [4:0]  t_sh [12] = '{5'd0, 5'd0, 5'd16, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1};
    logic [31:0] t_e  [12] = '{32'h40000000, 32'hFFFFFFFE, 32'h00030000, 32'h2, 32'h7FFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'h2, 32'hFFFFFFFB, 32'h23, 32'hFFFFFFFF, 32'hFFFFFFFF};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rep(input logic [31:0] v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [511:0] ramp(input int mult, input logic [15:0] m);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = m[i] ? 32'(i * mult) : 32'h0;
        return r;
    endfunction

    // Issues in the current cycle; returns in the out_valid cycle (lat = cycles after accept).
    task automatic run_op(input logic [2:0] o, input logic [511:0] a, input logic [511:0] b,
                          input logic [4:0] sh, input logic [15:0] m, input logic [3:0] d,
                          input logic dwe, input int off_at, input int off_len,
                          output int lat, output int stl);
        op = {2'b00, o}; opA = a; opB = b; vshamt = sh; vmask = m;
        in_dst = d; in_dst_we = dwe; activate = 1'b1;
        step();
        activate = 1'b0;
        lat = -1;
        stl = 0;
        for (int c = 1; c <= 40; c++) begin
            en = !(c >= off_at && c < off_at + off_len);
            if (out_valid) begin
                lat = c;
                break;
            end
            if (stall) stl++;
            step();
        end
        en = 1'b1;
    endtask

    initial begin
        int lat, stl;
        logic seen;
        resetn = 1'b0; en = 1'b1; squash = 1'b0; activate = 1'b0; op = '0;
        opA = '0; opB = '0; vshamt = '0; vmask = '0; in_dst = '0; in_dst_we = 1'b0;
        step(); step();
        chk("rst_stall", stall, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_dst", out_dst, 0);
        chk("rst_dst_we", out_dst_we, 0);
        chk("rst_mask", out_dst_mask, 0);
        resetn = 1'b1;
        step();

        // MUL ramp: lane i = 3i, full mask
        run_op(3'b000, ramp(1, 16'hFFFF), rep(32'd3), 5'd0, 16'hFFFF, 4'h5, 1'b1, 0, 0, lat, stl);
        $display("mul_ramp: lat=%0d stall_cycles=%0d", lat, stl);
        chk("mul_lat", lat, 5);
        chk("mul_stall", stl, 4);
        chk("mul_result", result, ramp(3, 16'hFFFF));
        chk("mul_dst", out_dst, 4'h5);
        chk("mul_dst_we", out_dst_we, 1'b1);
        chk("mul_mask", out_dst_mask, 16'hFFFF);
        step();
        chk("mul_valid_pulse", out_valid, 0);
        chk("mul_hold", result, ramp(3, 16'hFFFF));

        // Arithmetic variants, issued back-to-back from the DONE cycle
        for (int k = 0; k < 12; k++) begin
            run_op(t_op[k], rep(t_a[k]), rep(t_b[k]), t_sh[k], 16'hFFFF, 4'(k), k[0], 0, 0, lat, stl);
            $display("vec%0d: op=%0d a=%h b=%h sh=%0d lat=%0d lane0=%h", k, t_op[k], t_a[k], t_b[k], t_sh[k], lat, result[31:0]);
            chk($sformatf("vec%0d_lat", k), lat, 5);
            chk($sformatf("vec%0d_result", k), result, rep(t_e[k]));
        end

        // Sparse mask inside active groups
        run_op(3'b000, ramp(1, 16'hFFFF), rep(32'd3), 5'd0, 16'h8421, 4'h2, 1'b0, 0, 0, lat, stl);
        $display("sparse_mask: lat=%0d", lat);
        chk("sparse_lat", lat, 5);
        chk("sparse_result", result, ramp(3, 16'h8421));
        chk("sparse_mask", out_dst_mask, 16'h8421);
        chk("sparse_dst_we", out_dst_we, 1'b0);

        // One active group
        run_op(3'b000, rep(32'd2), rep(32'd2), 5'd0, 16'h00F0, 4'h7, 1'b1, 0, 0, lat, stl);
        $display("mask_00f0: lat=%0d stall_cycles=%0d", lat, stl);
        chk("m00f0_lat", lat, SKIP ? 2 : 5);
        chk("m00f0_stall", stl, SKIP ? 1 : 4);
        chk("m00f0_result", result, {{8{32'h0}}, {4{32'h4}}, {4{32'h0}}});
        chk("m00f0_mask", out_dst_mask, 16'h00F0);

        // Fully masked
        run_op(3'b000, rep(32'd2), rep(32'd2), 5'd0, 16'h0000, 4'h3, 1'b1, 0, 0, lat, stl);
        $display("mask_0000: lat=%0d stall_cycles=%0d", lat, stl);
        chk("m0000_lat", lat, SKIP ? 1 : 5);
        chk("m0000_stall", stl, SKIP ? 0 : 4);
        chk("m0000_result", result, 0);
        chk("m0000_dst", out_dst, 4'h3);
        step();

        // Squash at T+2, new op accepted at T+3
        op = 5'd0; opA = ramp(1, 16'hFFFF); opB = rep(32'd3); vmask = 16'hFFFF; activate = 1'b1;
        step();
        activate = 1'b0;
        chk("sq_stall_t1", stall, 1);
        step();
        squash = 1'b1;
        step();
        squash = 1'b0;
        chk("sq_stall_t3", stall, 0);
        chk("sq_valid_t3", out_valid, 0);
        run_op(3'b000, ramp(1, 16'hFFFF), rep(32'd5), 5'd0, 16'hFFFF, 4'h9, 1'b1, 0, 0, lat, stl);
        $display("after_squash: lat=%0d", lat);
        chk("sq_new_lat", lat, 5);
        chk("sq_new_result", result, ramp(5, 16'hFFFF));
        step();

        // Squash together with activate in a non-busy cycle drops the op
        activate = 1'b1; squash = 1'b1; opB = rep(32'd11);
        step();
        activate = 1'b0; squash = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (stall || out_valid) seen = 1'b1;
            step();
        end
        $display("squash_activate: activity=%0d", seen);
        chk("sqact_none", seen, 0);
        chk("sqact_result_kept", result, ramp(5, 16'hFFFF));

        // en low for 3 cycles mid-operation
        run_op(3'b000, ramp(1, 16'hFFFF), rep(32'd7), 5'd0, 16'hFFFF, 4'hA, 1'b1, 2, 3, lat, stl);
        $display("en_gap: lat=%0d stall_cycles=%0d", lat, stl);
        chk("en_lat", lat, 8);
        chk("en_stall", stl, 7);
        chk("en_result", result, ramp(7, 16'hFFFF));
        step();

        // Asynchronous reset at T+3
        op = 5'd0; opA = ramp(1, 16'hFFFF); opB = rep(32'd9); vmask = 16'hFFFF; activate = 1'b1;
        step();
        activate = 1'b0;
        step(); step();
        chk("ar_stall_before", stall, 1);
        resetn = 1'b0;
        #1;
        chk("ar_stall", stall, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_result", result, 0);
        chk("ar_dst", out_dst, 0);
        chk("ar_dst_we", out_dst_we, 0);
        chk("ar_mask", out_dst_mask, 0);
        step();
        resetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid || stall) seen = 1'b1;
        end
        $display("after_reset: activity=%0d", seen);
        chk("ar_no_valid", seen, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/vmul_unit_tm.md
# vmul_unit_tm

Time-multiplexed vector multiply unit for the vector lane datapath, successor to the fixed 3-stage multiplier. It multiplies NUMLANES element pairs using NUMMULLANES physical multipliers, processing one group of NUMMULLANES lanes per cycle. It adds signed/unsigned high-half products, rounded and saturated fixed-point multiply, masked-lane zeroing, and optional skipping of fully-masked groups. It sits beside the ALU in the vector execute stage and writes back through the usual dst/we/mask sideband.

## Interface
- LOG2WIDTH, 5, log2 of element width; WIDTH=2**LOG2WIDTH
- LOG2NUMLANES, 4, log2 of lane count; NUMLANES=2**LOG2NUMLANES
- NUMMULLANES, 4, physical multipliers; must divide NUMLANES; G=NUMLANES/NUMMULLANES groups
- REGIDWIDTH, 4, destination register id width
- clk  in  1  clock, single clock domain
- resetn  in  1  reset, asynchronous, active-low
- en  in  1  pipeline enable; low freezes all state, no accept
- squash  in  1  kills the in-flight operation
- activate  in  1  issue request, accepted when en & ~stall
- op  in  5  opcode; only op[2:0] decoded
- opA, opB  in  NUMLANES*WIDTH  operands, lane i at [i*WIDTH +: WIDTH]
- vshamt  in  LOG2WIDTH  fixed-point shift amount
- vmask  in  NUMLANES  lane enables
- in_dst  in  REGIDWIDTH, in_dst_we  in  1  destination sideband
- stall  out  1  unit busy; upstream must hold
- result  out  NUMLANES*WIDTH  lane results
- out_valid  out  1  one-cycle result strobe
- out_dst  out  REGIDWIDTH, out_dst_we  out  1, out_dst_mask  out  NUMLANES  captured sideband

## Operation
- Accept cycle T: opA, opB, vmask, op, vshamt, dst, dst_we latched into operand buffer; active-group list computed.
- Each busy cycle: multipliers take the next active group (ascending group index) from the buffer; the processed result is registered into that group's slot of the result buffer.
- op[2:0]: 000 MUL low WIDTH bits; 001 MULH signed high half; 010 MULHU unsigned high half; 100 FXMUL signed: p=a*b (2W signed), add 1<<(vshamt-1) if vshamt≠0, arithmetic shift right vshamt, saturate to [-2^(W-1), 2^(W-1)-1]; 101 FXMULU same unsigned, saturate to 2^W-1; other codes behave as 000.
- Lanes with vmask bit 0 return 0 in result, in every configuration.
- out_dst_we = captured in_dst_we; out_dst_mask = captured vmask.
- States: IDLE, BUSY (group counter), DONE (out_valid cycle; also accepts a new op).

## Timing
- N = active groups (G without skip). Busy cycles T+1..T+N; stall high exactly those cycles.
- out_valid high in cycle T+N+1 for one cycle; result/out_dst* stable from then until the next out_valid.
- Back-to-back: next activate accepted in T+N+1.
- en low: counter, buffers, out_valid held; stall unchanged.
- squash in any busy cycle: return to IDLE next cycle, no out_valid, stall low next cycle; squash in the accept cycle kills that op.
- squash and activate in same non-busy cycle: squash wins, op dropped.
- resetn low (any time, asynchronously): stall=0, out_valid=0, result=0, out_dst=0, out_dst_we=0, out_dst_mask=0, state IDLE.
- NUMMULLANES==NUMLANES: G=1, latency 2, stall one cycle.

## Configuration
- VMUL_MASKSKIP_EN defined: groups whose vmask bits are all zero are skipped; N = count of groups with any mask bit set; N=0 gives out_valid at T+1 and no stall cycle.
- Undefined: all G groups always processed, N=G; result values identical to the defined case.

## Test plan
- WIDTH=32, NUMLANES=16, NUMMULLANES=4, MUL, vmask=0xFFFF, opA lane i=i, opB=3 -> lane i=3i, stall high T+1..T+4, out_valid at T+5 only.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; FXMUL vshamt=16, 0x00018000*0x00020000 -> 0x00030000; FXMUL vshamt=1, 3*1 -> 2; FXMUL vshamt=0, 0x7FFFFFFF*0x7FFFFFFF -> 0x7FFFFFFF.
- vmask=0x00F0, all operands 2*2 -> lanes 4-7 =4, others 0; with VMUL_MASKSKIP_EN out_valid at T+2, without at T+5.
- vmask=0x0000 with VMUL_MASKSKIP_EN -> out_valid at T+1, stall never high, result all 0.
- squash at T+2 -> no out_valid, stall low at T+3, new op accepted at T+3 completes normally at T+8.
- resetn pulled low at T+3 -> all outputs 0 immediately, no out_valid after release; en low for 3 cycles mid-op -> out_valid delayed exactly 3 cycles.
